// File: rtl/picorv_ctrl_pkg.sv
// Shared types for the picorv32 run controller: FSM states, run result
// encodings and the full-word byte-enable pattern.
package picorv_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RST_HOLD,
        RUN,
        FIN
    } state_e;

    typedef enum logic [1:0] {
        OK_LOAD = 2'd0,
        TRAP    = 2'd1,
        TIMEOUT = 2'd2,
        ABORT   = 2'd3
    } status_e;

    localparam logic [3:0] WEN_FULL = 4'hF;

endpackage

// File: rtl/picorv_imem_writer.sv
// Program-load datapath: accepts the host word stream and turns each beat into
// a registered full-word write on the instruction-memory port.
module picorv_imem_writer
    import picorv_ctrl_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              active,
    input  logic              abort,
    input  logic [ADDR_W:0]   load_words,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [DATA_W-1:0] ld_data,
    output logic              last_beat,
    output logic              empty,
    output logic              inst_mem_en,
    output logic [3:0]        inst_mem_wen,
    output logic [ADDR_W-1:0] inst_mem_addr,
    output logic [DATA_W-1:0] inst_mem_data
);
    localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};

    logic [ADDR_W:0]   clamped;
    logic [ADDR_W:0]   remaining;
    logic [ADDR_W-1:0] beat_idx;
    logic              accept;

    // The memory holds 2^ADDR_W words, so longer requests are cut to one full image.
    assign clamped   = (load_words > MAX_WORDS) ? MAX_WORDS : load_words;
    assign accept    = active && ld_valid && ld_ready && !abort;
    assign last_beat = accept && (remaining == (ADDR_W+1)'(1));
    assign empty     = (remaining == '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ld_ready      <= 1'b0;
            remaining     <= '0;
            beat_idx      <= '0;
            inst_mem_en   <= 1'b0;
            inst_mem_wen  <= '0;
            inst_mem_addr <= '0;
            inst_mem_data <= '0;
        end else begin
            inst_mem_en  <= 1'b0;
            inst_mem_wen <= '0;
            if (start) begin
                remaining <= clamped;
                beat_idx  <= '0;
                ld_ready  <= (clamped != '0);
            end else if (active && abort) begin
                ld_ready <= 1'b0;
            end else if (accept) begin
                inst_mem_en   <= 1'b1;
                inst_mem_wen  <= WEN_FULL;
                inst_mem_addr <= beat_idx;
                inst_mem_data <= ld_data;
                beat_idx      <= beat_idx + ADDR_W'(1);
                remaining     <= remaining - (ADDR_W+1)'(1);
                if (remaining == (ADDR_W+1)'(1)) begin
                    ld_ready <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/picorv_run_ctrl.sv
// Host-side sequencer for picorv32_top: program load, CPU reset hold and a
// bounded clk_en execution window ending on trap, timeout or abort.
module picorv_run_ctrl
    import picorv_ctrl_pkg::*;
#(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 32,
    parameter int RST_CYCLES = 100
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start_load,
    input  logic [ADDR_W:0]   load_words,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              start_run,
    input  logic [31:0]       run_cycles,
    input  logic              abort,
    input  logic              trap,
    output logic              inst_mem_en,
    output logic [3:0]        inst_mem_wen,
    output logic [ADDR_W-1:0] inst_mem_addr,
    output logic [DATA_W-1:0] inst_mem_data,
    output logic              cpu_resetn,
    output logic              cpu_clk_en,
    output logic              scope_trig,
    output logic              busy,
    output logic              done,
    output logic [1:0]        status,
    output logic [31:0]       cycle_count
);
    localparam logic [31:0] HOLD_LAST = 32'(RST_CYCLES - 1);

    state_e      state;
    status_e     result;
    logic [31:0] hold_cnt;
    logic [31:0] run_limit;
    logic [31:0] count_next;
    logic        load_start;
    logic        load_active;
    logic        load_last;
    logic        load_empty;
    logic        abortable;

    assign load_start  = (state == IDLE) && start_load;
    assign load_active = (state == LOAD);
    assign abortable   = (state == LOAD) || (state == RST_HOLD) || (state == RUN);
    assign count_next  = cycle_count + 32'd1;
    assign status      = result;
    assign scope_trig  = cpu_clk_en;

    picorv_imem_writer #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_writer (
        .clk           (clk),
        .resetn        (resetn),
        .start         (load_start),
        .active        (load_active),
        .abort         (abort),
        .load_words    (load_words),
        .ld_valid      (ld_valid),
        .ld_ready      (ld_ready),
        .ld_data       (ld_data),
        .last_beat     (load_last),
        .empty         (load_empty),
        .inst_mem_en   (inst_mem_en),
        .inst_mem_wen  (inst_mem_wen),
        .inst_mem_addr (inst_mem_addr),
        .inst_mem_data (inst_mem_data)
    );

    // After trap or timeout the CPU stays out of reset with its clock gated so
    // its state can be inspected; only abort pushes it back into reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            result      <= OK_LOAD;
            busy        <= 1'b0;
            done        <= 1'b0;
            cpu_resetn  <= 1'b0;
            cpu_clk_en  <= 1'b0;
            cycle_count <= '0;
            hold_cnt    <= '0;
            run_limit   <= '0;
        end else begin
            done <= 1'b0;
            if (abort && abortable) begin
                state      <= FIN;
                result     <= ABORT;
                done       <= 1'b1;
                cpu_resetn <= 1'b0;
                cpu_clk_en <= 1'b0;
                if (state == RUN) begin
                    cycle_count <= count_next;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (start_load) begin
                            state      <= LOAD;
                            busy       <= 1'b1;
                            cpu_resetn <= 1'b0;
                        end else if (start_run) begin
                            state       <= RST_HOLD;
                            busy        <= 1'b1;
                            cpu_resetn  <= 1'b0;
                            cycle_count <= '0;
                            hold_cnt    <= '0;
                            run_limit   <= run_cycles;
                        end
                    end
                    LOAD: begin
                        if (load_last || load_empty) begin
                            state  <= FIN;
                            result <= OK_LOAD;
                            done   <= 1'b1;
                        end
                    end
                    RST_HOLD: begin
                        if (hold_cnt == HOLD_LAST) begin
                            cpu_resetn <= 1'b1;
                            if (run_limit == '0) begin
                                state  <= FIN;
                                result <= TIMEOUT;
                                done   <= 1'b1;
                            end else begin
                                state      <= RUN;
                                cpu_clk_en <= 1'b1;
                            end
                        end else begin
                            hold_cnt <= hold_cnt + 32'd1;
                        end
                    end
                    RUN: begin
                        cycle_count <= count_next;
                        if (trap) begin
                            state      <= FIN;
                            result     <= TRAP;
                            done       <= 1'b1;
                            cpu_clk_en <= 1'b0;
                        end else if (count_next == run_limit) begin
                            state      <= FIN;
                            result     <= TIMEOUT;
                            done       <= 1'b1;
                            cpu_clk_en <= 1'b0;
                        end
                    end
                    FIN: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/picorv_run_ctrl.md
Name: picorv_run_ctrl

Overview:
Host-side sequencer for the picorv32_top evaluation core. It streams a program image into the core's instruction-memory write port, holds the CPU in reset for a fixed period, then opens a bounded clk_en execution window. It ends each run on trap, timeout or abort, and reports status plus the enabled-cycle count. It sits between the host command/stream interface and the picorv32_top inst_mem_*, resetn and clk_en inputs, and it also drives a scope trigger for trace capture.

Parameters:
ADDR_W, 12, instruction-memory word-address width.
DATA_W, 32, instruction word width.
RST_CYCLES, 100, cycles cpu_resetn is held low at the start of each run (minimum 1).

Ports:
clk  in  1  system clock; also drives the instruction-memory clock.
resetn  in  1  asynchronous active-low reset.
start_load  in  1  single-cycle pulse that starts a program load; sampled only in IDLE.
load_words  in  ADDR_W+1  number of words to load, captured on start_load; values above 2^ADDR_W are clamped to 2^ADDR_W.
ld_valid  in  1  program word valid.
ld_ready  out  1  program word accepted when ld_valid && ld_ready.
ld_data  in  DATA_W  program word.
start_run  in  1  single-cycle pulse that starts a run; sampled only in IDLE.
run_cycles  in  32  execution window length in enabled cycles, captured on start_run.
abort  in  1  level input; terminates a load or run.
trap  in  1  CPU trap input from picorv32_top.
inst_mem_en  out  1  instruction-memory write enable strobe.
inst_mem_wen  out  4  byte write enables.
inst_mem_addr  out  ADDR_W  word address.
inst_mem_data  out  DATA_W  write data.
cpu_resetn  out  1  CPU reset, active-low.
cpu_clk_en  out  1  CPU clock enable.
scope_trig  out  1  high exactly while cpu_clk_en is high.
busy  out  1  high when the FSM is not in IDLE.
done  out  1  one-cycle pulse when a load or run completes or is aborted.
status  out  2  run result: 0 = OK_LOAD, 1 = TRAP, 2 = TIMEOUT, 3 = ABORT.
cycle_count  out  32  enabled cycles executed in the last run.

Behaviour:
- Reset: resetn is asynchronous and active-low. All outputs are 0 during reset, including cpu_resetn (CPU held in reset) and ld_ready. The FSM returns to IDLE; any load or run in progress is discarded and no done pulse is generated.
- All outputs are registered.
- FSM states: IDLE, LOAD, RST_HOLD, RUN, FIN.
- IDLE transitions:
  - start_load moves to LOAD.
  - start_run moves to RST_HOLD.
  - If both are asserted in the same cycle, start_load wins and start_run is dropped.
  - Start pulses outside IDLE are ignored.
- LOAD:
  - ld_ready = 1.
  - Each accepted beat produces, on the next cycle: inst_mem_en = 1, inst_mem_wen = 4'hF, inst_mem_addr = beat index, inst_mem_data = ld_data. Otherwise inst_mem_en = 0 and inst_mem_wen = 0.
  - The beat index starts at 0 and wraps at 2^ADDR_W. No more than 2^ADDR_W beats are accepted.
  - After the last accepted beat: ld_ready drops in the same cycle as that write is presented, the FSM goes to FIN, and status = OK_LOAD.
  - load_words = 0: go to FIN on the next cycle with no writes.
  - cpu_resetn stays 0 throughout LOAD.
- RST_HOLD:
  - cpu_resetn = 0 and cpu_clk_en = 0 for exactly RST_CYCLES cycles.
  - cycle_count clears to 0 on entry.
- RUN:
  - cpu_resetn = 1 and cpu_clk_en = 1.
  - cycle_count increments on each cycle with cpu_clk_en = 1.
  - Exit on trap: status = TRAP.
  - Exit on timeout, when cycle_count reaches run_cycles: status = TIMEOUT.
  - trap and timeout in the same cycle: TRAP wins.
  - run_cycles = 0: TIMEOUT immediately after RST_HOLD, with cpu_clk_en never asserted.
  - On exit, cpu_clk_en drops on the next edge, cpu_resetn stays 1 (CPU frozen, state inspectable), and cycle_count holds its value.
- abort:
  - In LOAD, RST_HOLD or RUN: next cycle cpu_clk_en = 0, cpu_resetn = 0, inst_mem_en = 0, FSM goes to FIN with status = ABORT.
  - abort wins over trap and timeout in the same cycle.
  - In IDLE or FIN it is ignored.
- FIN: done = 1 for exactly one cycle, then IDLE. busy = 0 from IDLE onward.

Decomposition:
- Package picorv_ctrl_pkg holds the FSM state enum, the status encodings (OK_LOAD, TRAP, TIMEOUT, ABORT) and WEN_FULL = 4'hF.
- One sub-module, picorv_imem_writer, owns the LOAD datapath: stream handshake, address counter with wrap/clamp, and the registered inst_mem_* outputs.
- The FSM and run counters stay in the top level.

Test Plan:
- Load 4 words (0x00000013, 0x00100093, 0x00000073, 0xDEADBEEF) with ld_valid gapped every other cycle -> exactly 4 writes at addresses 0..3 with wen = F; done pulses once; status = 0.
- load_words = 0, then load_words = 5000 with a continuous stream -> first: done with no writes. Second: 4096 writes, address wraps 4095 -> stops, ld_ready drops after beat 4096.
- start_run with run_cycles = 1000, trap asserted at the 50th enabled cycle -> cpu_resetn low for 100 cycles, cpu_clk_en high for 50 cycles, status = 1, cycle_count = 50, scope_trig equal to cpu_clk_en.
- start_run with run_cycles = 1000, no trap -> exactly 1000 enabled cycles, status = 2; also trap on cycle 1000 -> status = 1.
- abort at cycle 300 of a run, and abort coincident with trap -> cpu_clk_en = 0 and cpu_resetn = 0 next cycle, status = 3; the start_load pulse simultaneous with start_run from IDLE performs the load only.
- resetn asserted mid-load after 2 beats -> all outputs 0 immediately, no done pulse; a fresh load afterwards starts at address 0.
